// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32I core.
// A one-entry hold buffer keeps the in-flight fetch during a stall, so releasing the stall costs no bubble.
module if_stage #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_en,
    input  logic [31:0]         imem_rdata,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic [31:0]         if_id_instr,
    output logic [6:0]          if_id_opcode,
    output logic                if_id_valid
);

    logic [PC_WIDTH-1:0] pc;
    logic                inflight;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic                buf_valid;
    logic [31:0]         buf_instr;
    logic [PC_WIDTH-1:0] buf_pc;

    assign imem_addr    = pc;
    assign imem_en      = rst_n & ~stall & ~branch_taken;
    assign if_id_opcode = if_id_instr[6:0];

    // Fetch side: PC, in-flight tracking and the stall hold buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            buf_valid   <= 1'b0;
            buf_instr   <= NOP_INSTR;
            buf_pc      <= '0;
        end else if (branch_taken) begin
            pc        <= branch_target;
            inflight  <= 1'b0;
            buf_valid <= 1'b0;
        end else if (stall) begin
            inflight <= 1'b0;
            if (inflight) begin
                buf_instr <= imem_rdata;
                buf_pc    <= inflight_pc;
                buf_valid <= 1'b1;
            end
        end else begin
            pc          <= pc + PC_WIDTH'(4);
            inflight    <= 1'b1;
            inflight_pc <= pc;
            // The buffer is either consumed or squashed by a flush this cycle.
            buf_valid   <= 1'b0;
        end
    end

    // IF/ID register: buffered word takes precedence over the memory return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (branch_taken || flush) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (!stall) begin
            if (buf_valid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= buf_pc;
                if_id_instr <= buf_instr;
            end else if (inflight) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= inflight_pc;
                if_id_instr <= imem_rdata;
            end else begin
                if_id_valid <= 1'b0;
                if_id_pc    <= '0;
                if_id_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage with IF/ID pipeline register for the RV32I core. It owns the PC, issues requests to a synchronous instruction memory with 1-cycle read latency, and handles stall, flush and branch redirect. It delivers a registered instruction, its PC and its opcode field to decode; if_id_opcode drives control.opcode directly. A one-entry hold buffer keeps the in-flight fetch during stalls, so stall release costs no bubble.

Parameters:
PC_WIDTH, 32, width of all PC/address signals
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold IF/ID and PC (hazard unit)
flush  in  1  squash IF/ID contents next edge
branch_taken  in  1  redirect fetch to branch_target
branch_target  in  PC_WIDTH  redirect address, 4-byte aligned
imem_addr  out  PC_WIDTH  fetch address (= pc register)
imem_en  out  1  fetch request this cycle
imem_rdata  in  32  instruction for request issued previous cycle
if_id_pc  out  PC_WIDTH  PC of instruction in IF/ID
if_id_instr  out  32  registered instruction
if_id_opcode  out  7  if_id_instr[6:0]
if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Internal regs: pc, inflight, inflight_pc, buf_valid, buf_instr, buf_pc, plus IF/ID regs.
- Reset (async, rst_n=0): pc=RESET_PC, inflight=0, buf_valid=0, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_opcode=7'b0010011. imem_en=0 while rst_n=0.
- imem_addr=pc. imem_en = rst_n & ~stall & ~branch_taken.
- Issue (imem_en=1): pc<=pc+4 (mod 2^PC_WIDTH, wraps), inflight<=1, inflight_pc<=pc. No issue: inflight<=0.
- The first cycle after reset issues RESET_PC. if_id_valid first goes 1 at the second edge after rst_n rises.
- Priority: branch_taken > stall > normal. flush is applied on top of stall/normal.
- branch_taken=1 (stall ignored): pc<=branch_target. inflight, buf_valid<=0 (discard). IF/ID<=bubble (valid 0, NOP_INSTR, pc 0). The target issues the next cycle. The target instruction reaches IF/ID 2 edges after the redirect edge.
- RUN (stall=0, no branch): IF/ID source = buffer if buf_valid, else imem_rdata/inflight_pc if inflight, else bubble. Using the buffer clears buf_valid.
- HOLD (stall=1, no branch): IF/ID holds. If inflight, capture buf_instr<=imem_rdata, buf_pc<=inflight_pc, buf_valid<=1. Further stall cycles keep the buffer. pc holds.
- Invariant: buf_valid and inflight are never both 1. Release from HOLD: cycle 1 takes from the buffer and issues pc; cycle 2 takes imem_rdata. No bubble, no duplicate.
- flush=1 (no branch): IF/ID<=bubble, even when stall=1. The source selected that cycle is discarded (buffer cleared) when stall=0. When stall=1, buffer capture proceeds normally.
- if_id_opcode is always if_id_instr[6:0] (register-derived, no combinational path from imem_rdata).
- Reset asserted mid-stream: immediate return to reset values. The buffer and in-flight data are lost.

Test Plan:
- Reset/boot: memory word at addr A = 32'h00A0_0093 + A. Release rst_n. imem_addr sequence 0,4,8. if_id_valid=0 after edge 1. Edge 2: if_id_pc=0, if_id_instr=32'h00A0_0093, if_id_opcode=7'b0010011.
- Straight line: memory loaded with R-type 0x002081B3, load 0x0000A103, store 0x0020A023, branch 0x00208463 at 0..12. IF/ID shows them on consecutive cycles. Opcodes are 0110011, 0000011, 0100011, 1100011.
- Stall 3 cycles with fetch of 8 in flight: IF/ID holds pc=4 during all 3 cycles. imem_en=0. After release, IF/ID shows pc 8 then 12 on back-to-back cycles. No skip, no repeat.
- Branch at steady state, target 0x40: next edge if_id_valid=0. imem_addr=0x40 the following cycle. if_id_pc=0x40 two edges after the redirect. branch_taken together with stall still redirects.
- Flush during stall: stall=1, flush=1 for 1 cycle, then stall=0. IF/ID is a bubble. The buffered instruction is still delivered after release.
- Async reset mid-stall with buf_valid=1: outputs return to reset values without a clock edge. Refetch starts at RESET_PC.
